counter_field: RTL and testbench

//  Register-file field with an embedded hardware counter. Software reaches it

---
 rtl/counter_field.sv | 119 +++++++++++
 tb/tb_counter_field.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_field.sv
// Register-file counter field: software aliases with optional read-clear,
// hardware up/down count by a variable step, sticky over/underflow, threshold.
module counter_field #(
  parameter int                   F_WIDTH    = 8,
  parameter int                   ALIAS_NUM  = 2,
  parameter int                   STEP_WIDTH = 4,
  parameter bit                   SATURATE   = 1'b1,
  parameter bit                   PRECEDENCE = 1'b0,
  parameter logic [ALIAS_NUM-1:0] RCLR_MASK  = 2'b10,
  parameter logic [F_WIDTH-1:0]   THRESHOLD  = 8'hF0,
  parameter logic [F_WIDTH-1:0]   RST_VALUE  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sync_rst,
  input  logic                           write_protect_en,
  input  logic [ALIAS_NUM-1:0]           sw_wr,
  input  logic [ALIAS_NUM-1:0]           sw_rd,
  input  logic [ALIAS_NUM*F_WIDTH-1:0]   sw_wr_data,
  input  logic                           hw_incr,
  input  logic [STEP_WIDTH-1:0]          hw_incr_val,
  input  logic                           hw_decr,
  input  logic [STEP_WIDTH-1:0]          hw_decr_val,
  output logic [F_WIDTH-1:0]             field_value,
  output logic                           overflow,
  output logic                           underflow,
  output logic                           thresh_hit,
  output logic                           swmod_out,
  output logic                           swacc_out
);
  localparam int W2     = F_WIDTH + 2;
  localparam bit TH_RST = (RST_VALUE >= THRESHOLD);

  logic [F_WIDTH-1:0] val_q, val_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, th_q, th_d;
  logic               swmod_q, swmod_d, swacc_q, swacc_d;

  logic               wr_eff, rclr, cnt, load_sw, do_cnt, sum_neg, sum_big;
  logic [F_WIDTH-1:0] wr_data, base, cnt_res;
  logic [W2-1:0]      inc_ext, dec_ext, delta, sum;

  // Descending scan so the lowest-index writer is the last assignment.
  always_comb begin
    wr_data = '0;
    for (int i = ALIAS_NUM-1; i >= 0; i--)
      if (sw_wr[i]) wr_data = sw_wr_data[i*F_WIDTH +: F_WIDTH];
  end

  assign wr_eff  = (|sw_wr) & ~write_protect_en;
  assign rclr    = |(sw_rd & RCLR_MASK);
  assign inc_ext = hw_incr ? W2'(hw_incr_val) : '0;
  assign dec_ext = hw_decr ? W2'(hw_decr_val) : '0;
  assign delta   = inc_ext - dec_ext;
  assign cnt     = |delta;
  assign base    = rclr ? '0 : val_q;
  // Two guard bits: top bit is sign, next one flags a carry past all-ones.
  assign sum     = {2'b00, base} + delta;
  assign sum_neg = sum[W2-1];
  assign sum_big = ~sum[W2-1] & sum[W2-2];

  assign load_sw = wr_eff & ~(PRECEDENCE & cnt);
  assign do_cnt  = cnt & ~(wr_eff & ~PRECEDENCE);

  always_comb begin
    cnt_res = sum[F_WIDTH-1:0];
    if (SATURATE) begin
      if (sum_neg)      cnt_res = '0;
      else if (sum_big) cnt_res = '1;
    end
  end

  always_comb begin
    val_d   = val_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    swmod_d = 1'b0;
    swacc_d = (|sw_wr) | (|sw_rd);
    if (sync_rst) begin
      val_d   = RST_VALUE;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      swacc_d = 1'b0;
    end else begin
      if (load_sw)     val_d = wr_data;
      else if (do_cnt) val_d = cnt_res;
      else if (rclr)   val_d = '0;
      swmod_d = load_sw;
      // Set beats clear when a count overflows in the same cycle.
      ovf_d = (do_cnt & sum_big) | (ovf_q & ~(wr_eff | rclr));
      unf_d = (do_cnt & sum_neg) | (unf_q & ~(wr_eff | rclr));
    end
    th_d = (val_d >= THRESHOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= RST_VALUE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      th_q    <= TH_RST;
      swmod_q <= 1'b0;
      swacc_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      th_q    <= th_d;
      swmod_q <= swmod_d;
      swacc_q <= swacc_d;
    end
  end

  assign field_value = val_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign thresh_hit  = th_q;
  assign swmod_out   = swmod_q;
  assign swacc_out   = swacc_q;
endmodule

// File: tb/tb_counter_field.sv
// Bench for counter_field: instance 0 saturates with SW precedence, instance 1
// wraps with HW precedence; both share stimulus and are scored against a model.
module tb_counter_field;
  typedef struct packed {
    logic [7:0] v;
    logic       o, u, t, m, a;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, sync_rst, wp;
  logic [1:0]  sw_wr, sw_rd;
  logic [15:0] sw_wr_data;
  logic        hw_incr, hw_decr;
  logic [3:0]  hw_incr_val, hw_decr_val;
  logic [7:0]  fv0, fv1;
  logic        ov0, ov1, un0, un1, th0, th1, sm0, sm1, sa0, sa1;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t q0[$], q1[$];
  int   mv[2];
  bit   mo[2], mu[2], mm[2], ma[2];

  always #5 clk = ~clk;

  counter_field #(.SATURATE(1'b1), .PRECEDENCE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sync_rst(sync_rst), .write_protect_en(wp),
    .sw_wr(sw_wr), .sw_rd(sw_rd), .sw_wr_data(sw_wr_data),
    .hw_incr(hw_incr), .hw_incr_val(hw_incr_val), .hw_decr(hw_decr), .hw_decr_val(hw_decr_val),
    .field_value(fv0), .overflow(ov0), .underflow(un0), .thresh_hit(th0),
    .swmod_out(sm0), .swacc_out(sa0));

  counter_field #(.SATURATE(1'b0), .PRECEDENCE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sync_rst(sync_rst), .write_protect_en(wp),
    .sw_wr(sw_wr), .sw_rd(sw_rd), .sw_wr_data(sw_wr_data),
    .hw_incr(hw_incr), .hw_incr_val(hw_incr_val), .hw_decr(hw_decr), .hw_decr_val(hw_decr_val),
    .field_value(fv1), .overflow(ov1), .underflow(un1), .thresh_hit(th1),
    .swmod_out(sm1), .swacc_out(sa1));

  // Scoreboard monitor: one expectation per driven cycle, checked after the edge.
  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      g = {fv0, ov0, un0, th0, sm0, sa0};
      n_checks++;
      if (g !== e) $display("FAIL sb_dut0 t=%0t: got v=%h o%b u%b t%b m%b a%b want v=%h o%b u%b t%b m%b a%b",
                            $time, g.v, g.o, g.u, g.t, g.m, g.a, e.v, e.o, e.u, e.t, e.m, e.a);
      else n_pass++;
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      g = {fv1, ov1, un1, th1, sm1, sa1};
      n_checks++;
      if (g !== e) $display("FAIL sb_dut1 t=%0t: got v=%h o%b u%b t%b m%b a%b want v=%h o%b u%b t%b m%b a%b",
                            $time, g.v, g.o, g.u, g.t, g.m, g.a, e.v, e.o, e.u, e.t, e.m, e.a);
      else n_pass++;
    end
  end

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mv[c] = 0; mo[c] = 0; mu[c] = 0; mm[c] = 0; ma[c] = 0;
    end
  endtask

  // Integer reference model; config c: 0 = saturate/SW wins, 1 = wrap/HW wins.
  task automatic model_step();
    int  delta, base, s;
    bit  weff, rclr, cnt, sat, hwwins, clr;
    obs_t e;
    delta = (hw_incr ? int'(hw_incr_val) : 0) - (hw_decr ? int'(hw_decr_val) : 0);
    weff  = (sw_wr != 2'b00) && !wp;
    rclr  = sw_rd[1];
    cnt   = (delta != 0);
    for (int c = 0; c < 2; c++) begin
      sat = (c == 0); hwwins = (c == 1);
      if (sync_rst) begin
        mv[c] = 0; mo[c] = 0; mu[c] = 0; mm[c] = 0; ma[c] = 0;
      end else begin
        clr = weff || rclr;
        ma[c] = (sw_wr != 2'b00) || (sw_rd != 2'b00);
        mm[c] = 0;
        if (clr) begin mo[c] = 0; mu[c] = 0; end
        base = rclr ? 0 : mv[c];
        if (weff && !(hwwins && cnt)) begin
          mv[c] = sw_wr[0] ? int'(sw_wr_data[7:0]) : int'(sw_wr_data[15:8]);
          mm[c] = 1;
        end else if (cnt) begin
          s = base + delta;
          if (s > 255)    begin mo[c] = 1; mv[c] = sat ? 255 : s - 256; end
          else if (s < 0) begin mu[c] = 1; mv[c] = sat ? 0 : s + 256; end
          else mv[c] = s;
        end else if (rclr) mv[c] = 0;
      end
      e.v = mv[c][7:0]; e.o = mo[c]; e.u = mu[c]; e.t = (mv[c] >= 240); e.m = mm[c]; e.a = ma[c];
      if (c == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic drive(input logic sr, input logic p, input logic [1:0] wr, input logic [1:0] rd,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic inc, input logic [3:0] iv, input logic dec, input logic [3:0] dv);
    @(negedge clk);
    sync_rst = sr; wp = p; sw_wr = wr; sw_rd = rd; sw_wr_data = {d1, d0};
    hw_incr = inc; hw_incr_val = iv; hw_decr = dec; hw_decr_val = dv;
    model_step();
  endtask

  task automatic idle();
    drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 4'h0, 0, 4'h0);
  endtask

  task automatic wr0(input logic [7:0] d);
    drive(0, 0, 2'b01, 2'b00, d, 8'h00, 0, 4'h0, 0, 4'h0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst = 1; sync_rst = 0; wp = 0; sw_wr = 0; sw_rd = 0; sw_wr_data = 0;
    hw_incr = 0; hw_incr_val = 0; hw_decr = 0; hw_decr_val = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({fv0, ov0, un0, th0, sm0, sa0} !== 13'h0) $display("FAIL reset0: got %h want 0", {fv0, ov0, un0, th0, sm0, sa0});
    else n_pass++;
    n_checks++;
    if ({fv1, ov1, un1, th1, sm1, sa1} !== 13'h0) $display("FAIL reset1: got %h want 0", {fv1, ov1, un1, th1, sm1, sa1});
    else n_pass++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_saturate();
    wr0(8'hFE);
    drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 4'd3, 0, 4'd0);
    settle();
    n_checks++;
    if ({fv0, ov0} !== {8'hFF, 1'b1}) $display("FAIL sat_clamp: got %h/%b want FF/1", fv0, ov0); else n_pass++;
    n_checks++;
    if ({fv1, ov1} !== {8'h01, 1'b1}) $display("FAIL wrap_over: got %h/%b want 01/1", fv1, ov1); else n_pass++;
    drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 4'd3, 0, 4'd0);
    settle();
    n_checks++;
    if (fv0 !== 8'hFF) $display("FAIL sat_hold: got %h want FF", fv0); else n_pass++;
  endtask

  task automatic test_wrap();
    wr0(8'h02);
    drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 4'd0, 1, 4'd5);
    settle();
    n_checks++;
    if ({fv1, un1} !== {8'hFD, 1'b1}) $display("FAIL wrap_under: got %h/%b want FD/1", fv1, un1); else n_pass++;
    n_checks++;
    if ({fv0, un0} !== {8'h00, 1'b1}) $display("FAIL sat_under: got %h/%b want 00/1", fv0, un0); else n_pass++;
    wr0(8'h10);
    settle();
    n_checks++;
    if ({fv1, ov1, un1, sm1} !== {8'h10, 3'b001}) $display("FAIL wr_clr_flags: got %h%b%b%b want 10001", fv1, ov1, un1, sm1);
    else n_pass++;
  endtask

  task automatic test_precedence();
    wr0(8'h20);
    drive(0, 0, 2'b01, 2'b00, 8'h55, 8'h00, 1, 4'd2, 0, 4'd0);
    settle();
    n_checks++;
    if ({fv0, sm0} !== {8'h55, 1'b1}) $display("FAIL sw_wins: got %h/%b want 55/1", fv0, sm0); else n_pass++;
    n_checks++;
    if ({fv1, sm1, sa1} !== {8'h22, 2'b01}) $display("FAIL hw_wins: got %h/%b/%b want 22/0/1", fv1, sm1, sa1); else n_pass++;
  endtask

  task automatic test_thresh_rclr();
    wr0(8'hEF);
    drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 4'd1, 0, 4'd0);
    settle();
    n_checks++;
    if ({fv0, th0} !== {8'hF0, 1'b1}) $display("FAIL thresh_edge: got %h/%b want F0/1", fv0, th0); else n_pass++;
    drive(0, 0, 2'b00, 2'b10, 8'h00, 8'h00, 1, 4'd3, 0, 4'd0);
    settle();
    n_checks++;
    if ({fv0, ov0, un0, th0} !== {8'h03, 3'b000}) $display("FAIL rclr_count: got %h%b%b%b want 03000", fv0, ov0, un0, th0);
    else n_pass++;
  endtask

  task automatic test_protect();
    wr0(8'h30);
    drive(0, 1, 2'b01, 2'b00, 8'hAA, 8'h00, 0, 4'd0, 0, 4'd0);
    settle();
    n_checks++;
    if ({fv0, sm0, sa0} !== {8'h30, 2'b01}) $display("FAIL wprot: got %h/%b/%b want 30/0/1", fv0, sm0, sa0); else n_pass++;
    drive(0, 0, 2'b11, 2'b00, 8'h11, 8'h22, 0, 4'd0, 0, 4'd0);
    settle();
    n_checks++;
    if (fv0 !== 8'h11) $display("FAIL low_alias: got %h want 11", fv0); else n_pass++;
  endtask

  task automatic test_resets_mid();
    wr0(8'h7C);
    settle();
    #3 rst = 1;
    model_reset();
    #1;
    n_checks++;
    if ({fv0, fv1, th0} !== 17'h0) $display("FAIL async_rst: got %h/%h/%b want 00/00/0", fv0, fv1, th0); else n_pass++;
    @(negedge clk); rst = 0;
    wr0(8'hFE);
    drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 4'd3, 0, 4'd0);
    drive(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 4'd1, 0, 4'd0);
    settle();
    n_checks++;
    if ({fv0, ov0, un0} !== {8'h00, 2'b00}) $display("FAIL sync_rst: got %h%b%b want 0000", fv0, ov0, un0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] wr, rd;
      wr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rd = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0), wr, rd,
            8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
    end
    idle();
    settle();
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_precedence();
    test_thresh_rclr();
    test_protect();
    test_resets_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #3;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++;
      $display("FAIL sb_drain: got %0d/%0d left want 0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
